wfifo_axi_w_drain: RTL and testbench

- Read-side engine of the write-data FIFO. It pops 128-bit entries from the FIFO read port and emits them as AXI4 W-channel beats. Each burst is framed by a length command from the AW-side controller.
- Sits between the write FIFO (rd_en/rd_data/empty) and the AXI slave W channel. It is the consumer counterpart to the driver that pushes wr_en/wr_data.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer, so W stalls never drop or duplicate data.

---
 rtl/wfifo_drain_pkg.sv | 19 +
 rtl/wfifo_axi_w_drain_if.sv | 31 +++
 rtl/w_skid_buf.sv | 53 +++++
 rtl/wfifo_axi_w_drain.sv | 90 +++++++++
 tb/tb_wfifo_axi_w_drain.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wfifo_drain_pkg.sv
// Shared widths, types and FSM encoding for the write-FIFO W-channel drain engine.
package wfifo_drain_pkg;

  localparam int DATA_W    = 128;
  localparam int STRB_W    = DATA_W / 8;
  localparam int LEN_W     = 8;
  // Two slots cover one beat being presented plus one read returning from the FIFO.
  localparam int BUF_DEPTH = 2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [LEN_W-1:0]  len_t;

  typedef enum logic {
    IDLE,
    BURST
  } drain_state_e;

endpackage

// File: rtl/wfifo_axi_w_drain_if.sv
// Bundles the burst command, FIFO read port and AXI W channel seen by the drain engine.
interface wfifo_axi_w_drain_if
  import wfifo_drain_pkg::*;
;
  logic  cmd_valid;
  logic  cmd_ready;
  len_t  cmd_len;

  logic  fifo_empty;
  logic  fifo_rd_en;
  data_t fifo_rd_data;

  logic  m_wvalid;
  logic  m_wready;
  data_t m_wdata;
  strb_t m_wstrb;
  logic  m_wlast;

  // Drain engine side: accepts commands, pops the FIFO, drives W.
  modport master (
    input  cmd_valid, cmd_len, fifo_empty, fifo_rd_data, m_wready,
    output cmd_ready, fifo_rd_en, m_wvalid, m_wdata, m_wstrb, m_wlast
  );

  // Environment side: command source, FIFO and W-channel slave.
  modport slave (
    output cmd_valid, cmd_len, fifo_empty, fifo_rd_data, m_wready,
    input  cmd_ready, fifo_rd_en, m_wvalid, m_wdata, m_wstrb, m_wlast
  );

endinterface

// File: rtl/w_skid_buf.sv
// Two-entry ring buffer holding FIFO read data until the W channel takes it.
// Simultaneous push and pop keeps occupancy unchanged and preserves order.
module w_skid_buf
  import wfifo_drain_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  data_t      push_data,
  input  logic       pop,
  output data_t      head,
  output logic [1:0] count
);

  data_t      mem_reg [BUF_DEPTH];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;

  // Store incoming data in the slot selected by the write pointer; payload needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (push && (wr_ptr_reg == i[0])) begin
        mem_reg[i] <= push_data;
      end
    end
  end

  // Pointer and occupancy tracking; reset flushes the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/wfifo_axi_w_drain.sv
// Read-side engine of the write-data FIFO: pops entries and emits them as AXI4 W beats,
// one burst per length command. The skid buffer absorbs the FIFO's 1-cycle read latency.
module wfifo_axi_w_drain
  import wfifo_drain_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  wfifo_axi_w_drain_if.master  w,
  output logic                 busy
);

  drain_state_e     state_reg;
  logic [LEN_W:0]   total_reg;
  logic [LEN_W:0]   rd_cnt_reg;
  logic [LEN_W:0]   wr_cnt_reg;
  logic             inflight_reg;

  logic [1:0]       buf_cnt;
  data_t            buf_head;
  logic             pop_w;
  logic             rd_en;
  logic [2:0]       occ_next;

  assign pop_w = w.m_wvalid && w.m_wready;

  // Issue a FIFO read only when its data is guaranteed a buffer slot on return and the
  // burst still needs entries; never touch entries belonging to the next burst.
  always_comb begin
    occ_next = 3'(buf_cnt) + 3'(inflight_reg) - 3'(pop_w);
    rd_en    = 1'b0;
    if (!rst && (state_reg == BURST) && !w.fifo_empty &&
        (rd_cnt_reg < total_reg) && (occ_next < 3'(BUF_DEPTH))) begin
      rd_en = 1'b1;
    end
  end

  // Burst FSM with its counters; read data returning during reset is dropped by the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      total_reg    <= '0;
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      if (rd_en) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end
      if (pop_w) begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (w.cmd_valid) begin
            total_reg  <= {1'b0, w.cmd_len} + 1'b1;
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
            state_reg  <= BURST;
          end
        end
        BURST: begin
          if (pop_w && w.m_wlast) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  w_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (w.fifo_rd_data),
    .pop       (pop_w),
    .head      (buf_head),
    .count     (buf_cnt)
  );

  assign w.cmd_ready  = !rst && (state_reg == IDLE);
  assign w.fifo_rd_en = rd_en;
  assign w.m_wvalid   = (buf_cnt != 2'd0);
  assign w.m_wdata    = buf_head;
  assign w.m_wstrb    = '1;
  assign w.m_wlast    = w.m_wvalid && (wr_cnt_reg == total_reg - 1'b1);
  assign busy         = (state_reg == BURST);

endmodule

// File: tb/tb_wfifo_axi_w_drain.sv
// Scoreboard bench for the W-channel drain engine: stimulus feeds words into a FIFO model
// and queues them as expected beats; a negedge monitor pops and checks each W handshake.
module tb_wfifo_axi_w_drain;
  import wfifo_drain_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  wfifo_axi_w_drain_if w_if ();

  wfifo_axi_w_drain dut (
    .clk  (clk),
    .rst  (rst),
    .w    (w_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // FIFO model and scoreboard state
  data_t fifo_q[$];
  data_t feed_q[$];
  data_t exp_q[$];
  int    len_q[$];
  bit    pend_pop   = 1'b0;
  bit    rand_ready = 1'b0;
  bit    lat_check  = 1'b0;

  // monitor bookkeeping
  int    neg_cnt       = 0;
  int    pops_total    = 0;
  int    beats_total   = 0;
  int    burst_rd      = 0;
  int    beat_idx      = 0;
  int    accept_neg    = 0;
  int    last_beat_neg = 0;
  bit    first_seen    = 1'b0;
  bit    stall_prev    = 1'b0;
  bit    after_last    = 1'b0;
  data_t prev_data;
  logic  prev_last;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // FIFO model: pops at the edge after a sampled rd_en, presenting data in the next cycle.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      fifo_q.delete();
      feed_q.delete();
      pend_pop = 1'b0;
    end else begin
      if (pend_pop && fifo_q.size() > 0) w_if.fifo_rd_data = fifo_q.pop_front();
      pend_pop = 1'b0;
      while (feed_q.size() > 0) fifo_q.push_back(feed_q.pop_front());
    end
    w_if.fifo_empty = (fifo_q.size() == 0);
    w_if.m_wready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: one line per W transaction, compares against the expected stream.
  always @(negedge clk) begin
    bit    hs;
    bit    exp_last;
    data_t exp_d;
    neg_cnt++;
    if (rst) begin
      chk(!w_if.cmd_ready && !w_if.fifo_rd_en, "reset_outputs",
          {w_if.cmd_ready, w_if.fifo_rd_en}, 0);
      exp_q.delete();
      len_q.delete();
      pops_total  = 0;
      beats_total = 0;
      burst_rd    = 0;
      beat_idx    = 0;
      stall_prev  = 1'b0;
      after_last  = 1'b0;
      pend_pop    = 1'b0;
    end else begin
      hs = w_if.m_wvalid && w_if.m_wready;
      if (w_if.cmd_valid && w_if.cmd_ready) begin
        accept_neg = neg_cnt;
        first_seen = 1'b0;
        burst_rd   = 0;
      end
      if (w_if.fifo_rd_en) begin
        chk(!w_if.fifo_empty, "pop_while_empty", w_if.fifo_empty, 0);
        pops_total++;
        burst_rd++;
      end
      pend_pop = w_if.fifo_rd_en;
      if (hs) beats_total++;
      // words popped but not yet accepted = buffer + in-flight read
      chk((pops_total - beats_total) <= 2, "occupancy", pops_total - beats_total, 2);
      if (after_last) begin
        chk(!busy && w_if.cmd_ready && !w_if.m_wvalid, "idle_after_last",
            {busy, w_if.cmd_ready, w_if.m_wvalid}, 3'b010);
        after_last = 1'b0;
      end
      if (stall_prev) begin
        chk(w_if.m_wvalid && w_if.m_wdata == prev_data && w_if.m_wlast == prev_last,
            "stall_stable", w_if.m_wdata, prev_data);
      end
      stall_prev = w_if.m_wvalid && !w_if.m_wready;
      prev_data  = w_if.m_wdata;
      prev_last  = w_if.m_wlast;
      // first beat: accept edge -> BURST/rd_en -> data returns -> valid (3 negedges later)
      if (w_if.m_wvalid && !first_seen) begin
        first_seen = 1'b1;
        if (lat_check) chk(neg_cnt - accept_neg == 3, "first_beat_latency", neg_cnt - accept_neg, 3);
      end
      if (hs) begin
        if (lat_check && beat_idx > 0)
          chk(neg_cnt == last_beat_neg + 1, "back_to_back", neg_cnt - last_beat_neg, 1);
        last_beat_neg = neg_cnt;
        if (exp_q.size() == 0 || len_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", w_if.m_wdata, 0);
        end else begin
          exp_d    = exp_q.pop_front();
          exp_last = (beat_idx == len_q[0]);
          $display("beat %0d/%0d data=%0h last=%0b", beat_idx, len_q[0], w_if.m_wdata, w_if.m_wlast);
          chk(w_if.m_wdata == exp_d, "wdata", w_if.m_wdata, exp_d);
          chk(w_if.m_wlast == exp_last, "wlast", w_if.m_wlast, exp_last);
          chk(w_if.m_wstrb == {STRB_W{1'b1}}, "wstrb", w_if.m_wstrb, {STRB_W{1'b1}});
          if (exp_last) begin
            chk(burst_rd == len_q[0] + 1, "rd_count", burst_rd, len_q[0] + 1);
            void'(len_q.pop_front());
            beat_idx   = 0;
            after_last = 1'b1;
          end else begin
            beat_idx++;
          end
        end
      end
    end
  end

  task automatic feed_val(input data_t d);
    feed_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) feed_val({$urandom, $urandom, $urandom, $urandom});
  endtask

  // Present a command and hold it until accepted; returns one edge after acceptance.
  task automatic issue(input int len);
    int n = 0;
    @(posedge clk); #1;
    w_if.cmd_valid = 1'b1;
    w_if.cmd_len   = len_t'(len);
    @(negedge clk);
    while (!w_if.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(w_if.cmd_ready, "cmd_accept", w_if.cmd_ready, 1);
    len_q.push_back(len);
    $display("cmd len=%0d accepted", len);
    @(posedge clk); #1;
    w_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (!(len_q.size() == 0 && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(len_q.size() == 0 && !busy, "burst_done", len_q.size(), 0);
  endtask

  initial begin
    #400000;
    bad++;
    total++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int len;
    w_if.cmd_valid    = 1'b0;
    w_if.cmd_len      = '0;
    w_if.fifo_empty   = 1'b1;
    w_if.fifo_rd_data = '0;
    w_if.m_wready     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(!w_if.m_wvalid && !busy && !w_if.m_wlast && w_if.cmd_ready, "post_reset_state",
        {w_if.m_wvalid, busy, w_if.m_wlast, w_if.cmd_ready}, 4'b0001);

    // preloaded 1..4, len 3, ready always high
    for (int i = 1; i <= 4; i++) feed_val(data_t'(i));
    repeat (2) @(posedge clk);
    lat_check = 1'b1;
    issue(3);
    wait_done(50);
    lat_check = 1'b0;

    // single-beat burst
    feed(1);
    repeat (2) @(posedge clk);
    issue(0);
    wait_done(50);

    // len 7 with random back-pressure
    rand_ready = 1'b1;
    feed(8);
    issue(7);
    wait_done(200);
    rand_ready = 1'b0;

    // FIFO runs dry after one entry, refilled later
    feed(1);
    repeat (2) @(posedge clk);
    issue(3);
    repeat (5) @(negedge clk);
    chk(!w_if.m_wvalid && !w_if.fifo_rd_en && w_if.fifo_empty, "starved_idle",
        {w_if.m_wvalid, w_if.fifo_rd_en, w_if.fifo_empty}, 3'b001);
    @(posedge clk); #1;
    feed(3);
    wait_done(50);

    // reset during beat 2 of a len 7 burst
    feed(8);
    repeat (2) @(posedge clk);
    issue(7);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(!w_if.m_wvalid && !busy && w_if.cmd_ready, "state_after_mid_reset",
        {w_if.m_wvalid, busy, w_if.cmd_ready}, 3'b001);
    @(posedge clk); #1;
    feed(2);
    issue(1);
    wait_done(50);

    // 256-beat burst
    feed(256);
    issue(255);
    wait_done(400);

    // random bursts with the FIFO always holding a few entries of the next burst
    feed(3);
    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(0, 15);
      rand_ready = 1'($urandom_range(0, 1));
      feed(len + 1);
      issue(len);
      wait_done(200);
    end
    rand_ready = 1'b1;
    issue(2);
    wait_done(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
